// File: rtl/dac_spi_scheduler.sv
`timescale 1ns/1ps
// dac_spi_scheduler: round-robin scheduler that serialises two 16-bit audio
// sample streams into 24-bit SPI write frames for one dual-channel DAC.
// Frame = {CTRL_HI, 3'b000, chan, offset-binary sample}, MSB first.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | CS_ high, waiting for a full holding register
// SETUP | CS_ low, SCK low for one half-period before the first rise
// SHIFT | 24 SCK periods (high then low), SDI advances on falling edges
// HOLD  | SCK low, CS_ still low for one half-period after the last bit
// GAP   | CS_ high, enforces the minimum spacing before the next frame
module dac_spi_scheduler #(
    parameter int          CLK_DIV    = 2,
    parameter int          GAP_HALVES = 2,
    parameter logic [3:0]  CTRL_HI    = 4'h0
) (
    input  logic        CLK,
    input  logic        RESET_,
    input  logic        a_valid,
    input  logic [15:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [15:0] b_data,
    output logic        b_ready,
    output logic        DAC_SCK,
    output logic        DAC_SDI,
    output logic        DAC_CS_,
    output logic        busy,
    output logic        frame_done,
    output logic        last_chan
);

    localparam int HW      = $clog2(CLK_DIV + 1);
    localparam int GAP_CYC = GAP_HALVES * CLK_DIV;
    localparam int GW      = $clog2(GAP_CYC + 1);

    localparam logic [HW-1:0] HALF_LOAD = HW'(CLK_DIV - 1);
    localparam logic [HW-1:0] HALF_ONE  = HW'(1);
    localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_CYC - 1);
    localparam logic [GW-1:0] GAP_ONE   = GW'(1);
    localparam logic [4:0]    NUM_BITS  = 5'd24;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   half_q, half_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [4:0]      bit_q, bit_d;
    logic [23:0]     shreg_q, shreg_d;
    logic            sck_q, sck_d;
    logic            cs_q, cs_d;
    logic            fd_q, fd_d;
    logic            last_q, last_d;

    logic            a_full, b_full;
    logic [15:0]     a_hold, b_hold;

    logic            start, serve_b, load_a, load_b;
    logic [15:0]     sample;
    logic [23:0]     frame;

    // Round robin only matters on a tie; the channel not served last wins.
    always_comb begin
        start   = (state_q == IDLE) && (a_full || b_full);
        serve_b = b_full && (!a_full || !last_q);
        load_a  = start && !serve_b;
        load_b  = start && serve_b;
        sample  = serve_b ? b_hold : a_hold;
        frame   = {CTRL_HI, 3'b000, serve_b, ~sample[15], sample[14:0]};
    end

    // Holding registers: accept when empty, never overwrite while full.
    always_ff @(posedge CLK or negedge RESET_) begin
        if (!RESET_) begin
            a_full <= 1'b0;
            a_hold <= '0;
            b_full <= 1'b0;
            b_hold <= '0;
        end else begin
            if (a_valid && !a_full) begin
                a_full <= 1'b1;
                a_hold <= a_data;
            end else if (load_a) begin
                a_full <= 1'b0;
            end
            if (b_valid && !b_full) begin
                b_full <= 1'b1;
                b_hold <= b_data;
            end else if (load_b) begin
                b_full <= 1'b0;
            end
        end
    end

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        gap_d   = gap_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        sck_d   = sck_q;
        cs_d    = cs_q;
        fd_d    = 1'b0;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d = frame;
                    bit_d   = NUM_BITS;
                    half_d  = HALF_LOAD;
                    cs_d    = 1'b0;
                    sck_d   = 1'b0;
                    last_d  = serve_b;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (half_q == '0) begin
                    sck_d   = 1'b1;
                    bit_d   = bit_q - 5'd1;
                    half_d  = HALF_LOAD;
                    state_d = SHIFT;
                end else begin
                    half_d = half_q - HALF_ONE;
                end
            end
            SHIFT: begin
                if (half_q != '0) begin
                    half_d = half_q - HALF_ONE;
                end else begin
                    half_d = HALF_LOAD;
                    if (sck_q) begin
                        // bit_q counts rises still to come; after the last
                        // rise SDI is left alone for the trailing low phase.
                        sck_d = 1'b0;
                        if (bit_q != 5'd0) begin
                            shreg_d = {shreg_q[22:0], 1'b0};
                        end
                    end else if (bit_q == 5'd0) begin
                        state_d = HOLD;
                    end else begin
                        sck_d = 1'b1;
                        bit_d = bit_q - 5'd1;
                    end
                end
            end
            HOLD: begin
                if (half_q == '0) begin
                    cs_d    = 1'b1;
                    fd_d    = 1'b1;
                    shreg_d = '0;
                    gap_d   = GAP_LOAD;
                    state_d = GAP;
                end else begin
                    half_d = half_q - HALF_ONE;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GAP_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer registers; reset aborts any frame in flight.
    always_ff @(posedge CLK or negedge RESET_) begin
        if (!RESET_) begin
            state_q <= IDLE;
            half_q  <= '0;
            gap_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            sck_q   <= 1'b0;
            cs_q    <= 1'b1;
            fd_q    <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            gap_q   <= gap_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            sck_q   <= sck_d;
            cs_q    <= cs_d;
            fd_q    <= fd_d;
            last_q  <= last_d;
        end
    end

    assign a_ready    = ~a_full;
    assign b_ready    = ~b_full;
    assign DAC_SCK    = sck_q;
    assign DAC_SDI    = shreg_q[23];
    assign DAC_CS_    = cs_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = fd_q;
    assign last_chan  = last_q;

endmodule

// File: tb/tb_dac_spi_scheduler.sv
`timescale 1ns/1ps
// Bench for dac_spi_scheduler: an SPI bus model captures each CS_-framed
// word, expected words are queued as samples are offered, and each test
// task compares captured frames against them.
module tb_dac_spi_scheduler;

    localparam int D0 = 2;
    localparam int G0 = 2;
    localparam int D1 = 1;
    localparam int G1 = 1;
    localparam logic [3:0] CTRL_HI_TB = 4'h0;

    logic CLK = 1'b0;
    logic RESET_ = 1'b0;
    always #5 CLK = ~CLK;

    logic        a_valid, b_valid, a_ready, b_ready;
    logic [15:0] a_data, b_data;
    logic        sck0, sdi0, cs0, busy0, fd0, last0;

    logic        a1_valid, b1_valid, a1_ready, b1_ready;
    logic [15:0] a1_data, b1_data;
    logic        sck1, sdi1, cs1, busy1, fd1, last1;

    dac_spi_scheduler #(.CLK_DIV(D0), .GAP_HALVES(G0), .CTRL_HI(CTRL_HI_TB)) dut (
        .CLK(CLK), .RESET_(RESET_),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .DAC_SCK(sck0), .DAC_SDI(sdi0), .DAC_CS_(cs0),
        .busy(busy0), .frame_done(fd0), .last_chan(last0)
    );

    dac_spi_scheduler #(.CLK_DIV(D1), .GAP_HALVES(G1), .CTRL_HI(CTRL_HI_TB)) dut1 (
        .CLK(CLK), .RESET_(RESET_),
        .a_valid(a1_valid), .a_data(a1_data), .a_ready(a1_ready),
        .b_valid(b1_valid), .b_data(b1_data), .b_ready(b1_ready),
        .DAC_SCK(sck1), .DAC_SDI(sdi1), .DAC_CS_(cs1),
        .busy(busy1), .frame_done(fd1), .last_chan(last1)
    );

    typedef struct {
        logic [23:0] frame;
        int          nbits;
        int          cs_low;
        int          fall_cyc;
        int          rise_cyc;
        int          min_per;
        int          max_per;
        logic        last;
        logic        busy;
    } rec_t;

    rec_t        rxq0[$];
    rec_t        rxq1[$];
    logic [23:0] exp_a[$];
    logic [23:0] exp_b[$];

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    // Cycle stamp, stable whenever the negedge-side code reads it.
    always @(posedge CLK) cyc <= cyc + 1;

    logic [1:0] m_sck, m_cs, m_sdi, m_fd, m_last, m_busy;
    assign m_sck  = {sck1, sck0};
    assign m_cs   = {cs1, cs0};
    assign m_sdi  = {sdi1, sdi0};
    assign m_fd   = {fd1, fd0};
    assign m_last = {last1, last0};
    assign m_busy = {busy1, busy0};

    logic        p_sck [2] = '{1'b0, 1'b0};
    logic        p_cs  [2] = '{1'b1, 1'b1};
    bit          act   [2] = '{1'b0, 1'b0};
    logic [23:0] sh    [2];
    int          nb    [2] = '{0, 0};
    int          low   [2];
    int          fall_c[2];
    int          lrise [2];
    int          minp  [2];
    int          maxp  [2];
    int          fdc   [2] = '{0, 0};
    int          stray [2] = '{0, 0};
    rec_t        mon_r;

    // SPI bus model: DAC samples SDI on SCK rise while CS_ is low.
    always @(negedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            if (!RESET_) begin
                act[i] = 1'b0;
                nb[i]  = 0;
            end else begin
                if (!m_cs[i]) begin
                    if (p_cs[i]) begin
                        act[i] = 1'b1; nb[i] = 0; low[i] = 0; sh[i] = '0;
                        fall_c[i] = cyc; minp[i] = 1000000; maxp[i] = 0; lrise[i] = -1;
                    end
                    low[i]++;
                    if (m_sck[i] && !p_sck[i]) begin
                        sh[i] = {sh[i][22:0], m_sdi[i]};
                        nb[i]++;
                        if (lrise[i] >= 0) begin
                            if (cyc - lrise[i] < minp[i]) minp[i] = cyc - lrise[i];
                            if (cyc - lrise[i] > maxp[i]) maxp[i] = cyc - lrise[i];
                        end
                        lrise[i] = cyc;
                    end
                end else begin
                    if (m_sck[i] && !p_sck[i]) stray[i]++;
                    if (!p_cs[i] && act[i]) begin
                        mon_r.frame = sh[i];   mon_r.nbits = nb[i];   mon_r.cs_low = low[i];
                        mon_r.fall_cyc = fall_c[i]; mon_r.rise_cyc = cyc;
                        mon_r.min_per = minp[i]; mon_r.max_per = maxp[i];
                        mon_r.last = m_last[i]; mon_r.busy = m_busy[i];
                        $display("Channel %s: %h", sh[i][16] ? "B" : "A", {~sh[i][15], sh[i][14:0]});
                        if (i == 0) rxq0.push_back(mon_r); else rxq1.push_back(mon_r);
                        act[i] = 1'b0;
                    end
                end
                if (m_fd[i]) fdc[i]++;
            end
            p_sck[i] = m_sck[i];
            p_cs[i]  = m_cs[i];
        end
    end

    function automatic logic [23:0] exp_frame(input logic ch, input logic [15:0] s);
        logic [23:0] f;
        f[23:20] = CTRL_HI_TB;
        f[19:17] = 3'b000;
        f[16]    = ch;
        f[15]    = ~s[15];
        f[14:0]  = s[14:0];
        return f;
    endfunction

    task automatic pop_rx(input int which, output rec_t r);
        r.frame = 'x; r.nbits = -1; r.cs_low = -1; r.fall_cyc = -1; r.rise_cyc = -1;
        r.min_per = -1; r.max_per = -1; r.last = 1'bx; r.busy = 1'bx;
        if (which == 0 && rxq0.size() > 0) r = rxq0.pop_front();
        if (which == 1 && rxq1.size() > 0) r = rxq1.pop_front();
    endtask

    task automatic pop_exp(input logic ch, output logic [23:0] e);
        e = 'x;
        if (!ch && exp_a.size() > 0) e = exp_a.pop_front();
        if (ch && exp_b.size() > 0) e = exp_b.pop_front();
    endtask

    task automatic wait_rx(input int which, input int n, input int budget);
        int k;
        k = 0;
        while (((which == 0) ? rxq0.size() : rxq1.size()) < n && k < budget) begin
            @(posedge CLK);
            k++;
        end
        @(negedge CLK);
    endtask

    task automatic send_a(input logic [15:0] d, output int acc);
        int k;
        @(negedge CLK);
        a_valid = 1'b1; a_data = d; k = 0;
        while (!a_ready && k < 2000) begin @(negedge CLK); k++; end
        exp_a.push_back(exp_frame(1'b0, d));
        acc = cyc + 1;
        @(negedge CLK);
        a_valid = 1'b0;
    endtask

    task automatic send_b(input logic [15:0] d);
        int k;
        @(negedge CLK);
        b_valid = 1'b1; b_data = d; k = 0;
        while (!b_ready && k < 2000) begin @(negedge CLK); k++; end
        exp_b.push_back(exp_frame(1'b1, d));
        @(negedge CLK);
        b_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge CLK); #2;
        RESET_ = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0; a1_valid = 1'b0; b1_valid = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RESET_ = 1'b1;
        exp_a.delete(); exp_b.delete();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge CLK);
        checks++; if (cs0 !== 1'b1) begin fails++; $display("FAIL reset_cs: got %b want 1", cs0); end
        checks++; if (sck0 !== 1'b0) begin fails++; $display("FAIL reset_sck: got %b want 0", sck0); end
        checks++; if (sdi0 !== 1'b0) begin fails++; $display("FAIL reset_sdi: got %b want 0", sdi0); end
        checks++; if ({busy0, fd0} !== 2'b00) begin fails++; $display("FAIL reset_busy_fd: got %b want 00", {busy0, fd0}); end
        checks++; if (last0 !== 1'b1) begin fails++; $display("FAIL reset_last_chan: got %b want 1", last0); end
        checks++; if ({a_ready, b_ready} !== 2'b11) begin fails++; $display("FAIL reset_ready: got %b want 11", {a_ready, b_ready}); end
        checks++;
        if ({cs1, sck1, sdi1, busy1, last1, a1_ready, b1_ready} !== 7'b1000111) begin
            fails++; $display("FAIL reset_dut1: got %b want 1000111", {cs1, sck1, sdi1, busy1, last1, a1_ready, b1_ready});
        end
        RESET_ = 1'b1;
        repeat (5) @(negedge CLK);
        checks++; if ({cs0, busy0} !== 2'b10) begin fails++; $display("FAIL idle_no_valid: got %b want 10", {cs0, busy0}); end
    endtask

    task automatic test_single();
        rec_t r;
        int acc, fd_before;
        fd_before = fdc[0];
        send_a(16'h1234, acc);
        wait_rx(0, 1, 400);
        repeat (2) @(negedge CLK);
        pop_rx(0, r);
        void'(exp_a.pop_front());
        checks++; if (r.frame !== 24'h009234) begin fails++; $display("FAIL single_frame: got %h want 009234", r.frame); end
        checks++; if (r.nbits !== 24) begin fails++; $display("FAIL single_nbits: got %0d want 24", r.nbits); end
        checks++; if (r.cs_low !== 50 * D0) begin fails++; $display("FAIL single_cs_low: got %0d want %0d", r.cs_low, 50 * D0); end
        checks++; if (r.fall_cyc - acc !== 1) begin fails++; $display("FAIL single_cs_latency: got %0d want 1", r.fall_cyc - acc); end
        checks++;
        if (r.min_per !== 2 * D0 || r.max_per !== 2 * D0) begin
            fails++; $display("FAIL single_sck_period: got %0d..%0d want %0d", r.min_per, r.max_per, 2 * D0);
        end
        checks++; if (fdc[0] - fd_before !== 1) begin fails++; $display("FAIL single_frame_done: got %0d pulses want 1", fdc[0] - fd_before); end
        checks++; if ({r.last, r.busy} !== 2'b01) begin fails++; $display("FAIL single_last_busy: got %b want 01", {r.last, r.busy}); end
    endtask

    task automatic test_tie();
        rec_t r0, r1;
        do_reset();
        a_valid = 1'b1; a_data = 16'h8000;
        b_valid = 1'b1; b_data = 16'h7FFF;
        @(negedge CLK);
        a_valid = 1'b0; b_valid = 1'b0;
        wait_rx(0, 2, 600);
        pop_rx(0, r0);
        pop_rx(0, r1);
        checks++; if (r0.frame !== 24'h000000) begin fails++; $display("FAIL tie_first: got %h want 000000", r0.frame); end
        checks++; if (r1.frame !== 24'h01FFFF) begin fails++; $display("FAIL tie_second: got %h want 01ffff", r1.frame); end
        checks++;
        if (r1.rise_cyc - r0.rise_cyc !== (50 + G0) * D0 + 1) begin
            fails++; $display("FAIL tie_spacing: got %0d want %0d", r1.rise_cyc - r0.rise_cyc, (50 + G0) * D0 + 1);
        end
        checks++; if ({r0.last, r1.last} !== 2'b01) begin fails++; $display("FAIL tie_last_chan: got %b want 01", {r0.last, r1.last}); end
    endtask

    task automatic test_round_robin();
        rec_t r;
        logic [23:0] e;
        int na, nb_cnt, k;
        logic wa, wb;
        na = 0; nb_cnt = 0; k = 0;
        @(negedge CLK);
        a_data = 16'h0100; b_data = 16'hF200;
        a_valid = 1'b1; b_valid = 1'b1;
        while (rxq0.size() < 6 && k < 3000) begin
            wa = a_valid && a_ready;
            wb = b_valid && b_ready;
            if (wa) exp_a.push_back(exp_frame(1'b0, a_data));
            if (wb) exp_b.push_back(exp_frame(1'b1, b_data));
            @(negedge CLK);
            k++;
            if (wa) begin na++; a_data = a_data + 16'd1; end
            if (wb) begin nb_cnt++; b_data = b_data + 16'd1; end
            if (na == 3) a_valid = 1'b0;
            if (nb_cnt == 3) b_valid = 1'b0;
        end
        a_valid = 1'b0; b_valid = 1'b0;
        checks++; if (rxq0.size() !== 6) begin fails++; $display("FAIL rr_frame_count: got %0d want 6", rxq0.size()); end
        for (int i = 0; i < 6; i++) begin
            pop_rx(0, r);
            pop_exp(i[0], e);
            checks++; if (r.frame !== e) begin fails++; $display("FAIL rr_frame%0d: got %h want %h", i, r.frame, e); end
            checks++; if (r.last !== i[0]) begin fails++; $display("FAIL rr_last_chan%0d: got %b want %b", i, r.last, i[0]); end
        end
        checks++;
        if (exp_a.size() + exp_b.size() !== 0) begin
            fails++; $display("FAIL rr_leftover: got %0d unserved want 0", exp_a.size() + exp_b.size());
        end
        wait_rx(0, 1, 300);
        checks++; if (rxq0.size() !== 0) begin fails++; $display("FAIL rr_extra_frames: got %0d want 0", rxq0.size()); end
    endtask

    task automatic test_back_to_back();
        rec_t r[3];
        logic [23:0] e;
        int acc_c[3];
        int na, k;
        logic wa;
        na = 0; k = 0;
        @(negedge CLK);
        a_data = 16'h0001; a_valid = 1'b1;
        while (rxq0.size() < 3 && k < 3000) begin
            wa = a_valid && a_ready;
            if (wa) begin
                exp_a.push_back(exp_frame(1'b0, a_data));
                if (na < 3) acc_c[na] = cyc + 1;
            end
            @(negedge CLK);
            k++;
            if (wa) begin na++; a_data = a_data + 16'd1; end
            if (na == 3) a_valid = 1'b0;
        end
        a_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pop_rx(0, r[i]);
            pop_exp(1'b0, e);
            checks++; if (r[i].frame !== e) begin fails++; $display("FAIL b2b_frame%0d: got %h want %h", i, r[i].frame, e); end
        end
        checks++; if (acc_c[1] - r[0].fall_cyc !== 1) begin fails++; $display("FAIL b2b_accept2: got %0d want 1", acc_c[1] - r[0].fall_cyc); end
        checks++; if (acc_c[2] - r[1].fall_cyc !== 1) begin fails++; $display("FAIL b2b_accept3: got %0d want 1", acc_c[2] - r[1].fall_cyc); end
        checks++;
        if (r[2].rise_cyc - r[1].rise_cyc !== (50 + G0) * D0 + 1) begin
            fails++; $display("FAIL b2b_spacing: got %0d want %0d", r[2].rise_cyc - r[1].rise_cyc, (50 + G0) * D0 + 1);
        end
    endtask

    task automatic test_clkdiv1();
        rec_t r;
        int k;
        @(negedge CLK);
        b1_valid = 1'b1; b1_data = 16'hFFFF; k = 0;
        while (!b1_ready && k < 200) begin @(negedge CLK); k++; end
        @(negedge CLK);
        b1_valid = 1'b0;
        wait_rx(1, 1, 200);
        pop_rx(1, r);
        checks++; if (r.frame !== 24'h017FFF) begin fails++; $display("FAIL div1_frame: got %h want 017fff", r.frame); end
        checks++; if (r.nbits !== 24) begin fails++; $display("FAIL div1_nbits: got %0d want 24", r.nbits); end
        checks++; if (r.cs_low !== 50 * D1) begin fails++; $display("FAIL div1_cs_low: got %0d want %0d", r.cs_low, 50 * D1); end
        checks++;
        if (r.min_per !== 2 * D1 || r.max_per !== 2 * D1) begin
            fails++; $display("FAIL div1_sck_period: got %0d..%0d want %0d", r.min_per, r.max_per, 2 * D1);
        end
    endtask

    task automatic test_reset_abort();
        rec_t r;
        int acc, k;
        send_a(16'h4321, acc);
        send_b(16'h5555);
        k = 0;
        while (nb[0] < 10 && k < 500) begin @(posedge CLK); k++; end
        @(negedge CLK);
        checks++; if (b_ready !== 1'b0) begin fails++; $display("FAIL abort_b_held: got %b want 0", b_ready); end
        @(posedge CLK); #2;
        RESET_ = 1'b0;
        #1;
        checks++;
        if ({cs0, sck0, sdi0, busy0} !== 4'b1000) begin
            fails++; $display("FAIL abort_outputs: got %b want 1000", {cs0, sck0, sdi0, busy0});
        end
        checks++; if ({a_ready, b_ready} !== 2'b11) begin fails++; $display("FAIL abort_ready: got %b want 11", {a_ready, b_ready}); end
        exp_a.delete(); exp_b.delete();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RESET_ = 1'b1;
        repeat (20) @(negedge CLK);
        checks++; if (rxq0.size() !== 0) begin fails++; $display("FAIL abort_no_frame: got %0d frames want 0", rxq0.size()); end
        send_a(16'h0042, acc);
        wait_rx(0, 1, 400);
        repeat (150) @(negedge CLK);
        checks++; if (rxq0.size() !== 1) begin fails++; $display("FAIL abort_restart_count: got %0d frames want 1", rxq0.size()); end
        pop_rx(0, r);
        checks++; if (r.frame !== 24'h008042) begin fails++; $display("FAIL abort_restart_frame: got %h want 008042", r.frame); end
        checks++; if (r.cs_low !== 50 * D0) begin fails++; $display("FAIL abort_restart_cs_low: got %0d want %0d", r.cs_low, 50 * D0); end
        checks++; if (stray[0] + stray[1] !== 0) begin fails++; $display("FAIL stray_sck: got %0d want 0", stray[0] + stray[1]); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;
        a1_valid = 1'b0; b1_valid = 1'b0; a1_data = '0; b1_data = '0;
        RESET_ = 1'b0;
        test_reset();
        test_single();
        test_tie();
        test_round_robin();
        test_back_to_back();
        test_clkdiv1();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
